// File: rtl/tile_color_gen.sv
// tile_color_gen: tile-grid colour overlay for the VGA pixel path.
// The active area is split into TILES_X x TILES_Y tiles, each with its own
// colour register and painted flag. Repaint requests are held until the
// next frame_start and committed in blanking with a colour taken from a
// free-running 24-bit Galois LFSR. Pixel latency is two clocks.
// Optional feature macro: TILE_COLOR_BORDER_EN (white tile-edge grid lines).
module tile_color_gen #(
  parameter int          TILES_X = 4,
  parameter int          TILES_Y = 4,
  parameter int          TILE_W  = 128,
  parameter int          TILE_H  = 64,
  parameter int          X_ORG   = 144,
  parameter int          Y_ORG   = 35,
  parameter int          CW      = 8,
  parameter logic [23:0] SEED    = 24'hACE1F5,
  localparam int         NT      = TILES_X * TILES_Y,
  localparam int         SEL_W   = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             frame_start,
  input  logic             upd_req,
  input  logic [SEL_W-1:0] sel,
  input  logic             clr_req,
  output logic             upd_busy,
  output logic             upd_ack,
  input  logic [CW-1:0]    r_in,
  input  logic [CW-1:0]    g_in,
  input  logic [CW-1:0]    b_in,
  output logic [CW-1:0]    r_out,
  output logic [CW-1:0]    g_out,
  output logic [CW-1:0]    b_out
);

  localparam int          CBITS     = 3 * CW;
  localparam int          LOG_W     = $clog2(TILE_W);
  localparam int          LOG_H     = $clog2(TILE_H);
  localparam logic [10:0] X_ORG_L   = 11'(X_ORG);
  localparam logic [10:0] Y_ORG_L   = 11'(Y_ORG);
  localparam logic [10:0] GRID_W_L  = 11'(TILES_X * TILE_W);
  localparam logic [10:0] GRID_H_L  = 11'(TILES_Y * TILE_H);
  localparam logic [10:0] TILES_X_L = 11'(TILES_X);
  localparam logic [SEL_W:0] NT_L   = (SEL_W + 1)'(NT);
  // Galois feedback mask for x^24 + x^23 + x^22 + x^17 + 1 (right-shifting form)
  localparam logic [23:0] LFSR_MASK = 24'hE10000;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [23:0]        lfsr_q, lfsr_d;
  logic               clr_pend_q, clr_pend_d;
  logic [NT-1:0]      painted_q, painted_d;
  logic [CBITS-1:0]   color_q [NT];
  logic [CBITS-1:0]   color_d [NT];
  logic               commit_en;

  logic               hit_q, hit_d;
  logic [SEL_W-1:0]   tile_q, tile_d;
  logic [CBITS-1:0]   pix_q, pix_d;
  logic [CBITS-1:0]   out_q, out_d;
  logic [10:0]        dx, dy, tx, ty;
`ifdef TILE_COLOR_BORDER_EN
  localparam logic [10:0] MASK_W = 11'(TILE_W - 1);
  localparam logic [10:0] MASK_H = 11'(TILE_H - 1);
  logic               border_q, border_d;
`endif

  // LFSR advances every clock; an all-zero state would lock up, so reload SEED
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_MASK;
    end
    if (lfsr_q == 24'h0) begin
      lfsr_d = SEED;
    end
  end

  // Control FSM: accept in IDLE, wait for blanking in PENDING, write in COMMIT
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    upd_busy  = 1'b0;
    upd_ack   = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (upd_req) begin
          sel_d   = sel;
          state_d = PENDING;
        end
      end
      PENDING: begin
        upd_busy = 1'b1;
        if (frame_start) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        upd_ack   = 1'b1;
        commit_en = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tile store: sticky clear resolves on frame_start, commits land a cycle later
  always_comb begin
    painted_d  = painted_q;
    color_d    = color_q;
    clr_pend_d = clr_pend_q | clr_req;
    if (frame_start && clr_pend_d) begin
      painted_d  = '0;
      clr_pend_d = 1'b0;
    end
    if (commit_en && ({1'b0, sel_q} < NT_L)) begin
      painted_d[sel_q] = 1'b1;
      color_d[sel_q]   = lfsr_q[23 -: CBITS];
    end
  end

  // Stage 1: grid hit test and tile number from 11-bit origin-relative offsets
  always_comb begin
    dx     = {1'b0, x} - X_ORG_L;
    dy     = {1'b0, y} - Y_ORG_L;
    hit_d  = ({1'b0, x} >= X_ORG_L) && (dx < GRID_W_L) &&
             ({1'b0, y} >= Y_ORG_L) && (dy < GRID_H_L);
    tx     = dx >> LOG_W;
    ty     = dy >> LOG_H;
    tile_d = SEL_W'(ty * TILES_X_L + tx);
    pix_d  = {r_in, g_in, b_in};
`ifdef TILE_COLOR_BORDER_EN
    border_d = hit_d && (((dx & MASK_W) == 11'd0) || ((dy & MASK_H) == 11'd0));
`endif
  end

  // Stage 2: painted tiles override the delayed input colour
  always_comb begin
    out_d = pix_q;
    if (hit_q && painted_q[tile_q]) begin
      out_d = color_q[tile_q];
    end
`ifdef TILE_COLOR_BORDER_EN
    if (border_q) begin
      out_d = '1;
    end
`endif
  end

  // All state registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      lfsr_q     <= SEED;
      clr_pend_q <= 1'b0;
      painted_q  <= '0;
      for (int i = 0; i < NT; i++) begin
        color_q[i] <= '0;
      end
      hit_q      <= 1'b0;
      tile_q     <= '0;
      pix_q      <= '0;
      out_q      <= '0;
`ifdef TILE_COLOR_BORDER_EN
      border_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      lfsr_q     <= lfsr_d;
      clr_pend_q <= clr_pend_d;
      painted_q  <= painted_d;
      for (int i = 0; i < NT; i++) begin
        color_q[i] <= color_d[i];
      end
      hit_q      <= hit_d;
      tile_q     <= tile_d;
      pix_q      <= pix_d;
      out_q      <= out_d;
`ifdef TILE_COLOR_BORDER_EN
      border_q   <= border_d;
`endif
    end
  end

  assign r_out = out_q[CBITS-1 -: CW];
  assign g_out = out_q[2*CW-1 -: CW];
  assign b_out = out_q[CW-1:0];

endmodule

// File: doc/tile_color_gen.md
# tile_color_gen

Parametrised tile-based colour overlay for the VGA pixel path. The active area is divided into a TILES_X × TILES_Y grid of fixed-size tiles, each holding its own colour register. Painted tiles show their stored colour, while unpainted or out-of-grid pixels pass the incoming colour through. The block sits between the pixel-colour source and the DAC output stage, driven by the VGA timing generator's x/y counters.

## Interface
- TILES_X, 4, tile columns (≥1)
- TILES_Y, 4, tile rows (≥1)
- TILE_W, 128, tile width in pixels, power of two
- TILE_H, 64, tile height in pixels, power of two
- X_ORG, 144, x counter value of the grid's left edge
- Y_ORG, 35, y counter value of the grid's top edge
- CW, 8, bits per colour channel
- SEED, 24'hACE1F5, LFSR reset value, nonzero
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- x, y  in  10  current pixel counters
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- upd_req  in  1  request to repaint one tile
- sel  in  SEL_W=max(1,$clog2(TILES_X*TILES_Y))  tile number (row-major: ty*TILES_X+tx)
- clr_req  in  1  request to unpaint all tiles
- upd_busy  out  1  request pending; new requests are ignored
- upd_ack  out  1  one-cycle pulse when a commit completes
- r_in, g_in, b_in  in  CW  pass-through colour
- r_out, g_out, b_out  out  CW  output colour

## Operation
- Colour source: a 24-bit Galois LFSR (taps x^24+x^23+x^22+x^17+1) advances every clk. The top 3·CW bits (CW≤8) give {r,g,b}, MSB first. If the state ever reads zero, the LFSR reloads SEED.
- Control FSM states are IDLE, PENDING and COMMIT.
  - IDLE: when upd_req=1, latch sel into sel_q and go to PENDING.
  - PENDING: upd_busy=1; upd_req is ignored. On frame_start, go to COMMIT.
  - COMMIT: one cycle. If sel_q < TILES_X*TILES_Y, load that tile's colour register from the current LFSR value and set its painted flag; an out-of-range sel_q writes nothing. Then pulse upd_ack=1 and return to IDLE.
- clr_req is sticky. It is cleared at the next frame_start, which also clears all painted flags on that edge. The colour registers themselves are not cleared.
- Pixel path:
  - Grid hit: in_grid = (x ≥ X_ORG) && (x−X_ORG < TILES_X·TILE_W) && (y ≥ Y_ORG) && (y−Y_ORG < TILES_Y·TILE_H).
  - Tile coordinates: tx=(x−X_ORG)>>log2(TILE_W) and ty=(y−Y_ORG)>>log2(TILE_H). Subtractions are 11-bit to avoid wrap.
  - Output: if in_grid and the tile is painted, output the tile colour; otherwise output the delayed r_in/g_in/b_in.

## Timing
- Reset values:
  - r_out/g_out/b_out = 0
  - upd_busy = upd_ack = 0
  - all painted flags = 0
  - colour registers = 0
  - LFSR = SEED
  - FSM = IDLE
  - clr pending = 0
- Pixel latency is exactly 2 clk from x/y/r_in/g_in/b_in to output:
  - Stage 1 registers in_grid, the tile number and the input colour.
  - Stage 2 registers the mux result.
- upd_req and frame_start in the same cycle while in IDLE: the request is latched. The commit happens on the following frame_start, not the current one.
- upd_busy rises the cycle after acceptance and falls in the cycle upd_ack is high.
- A commit and a pending clear on the same frame_start: the clear applies first, and the committed tile ends painted.
- A tile repainted mid-frame takes effect at the stage-1 lookup of the next pixel. Because commits only occur during blanking, no tearing occurs.
- Reset asserted mid-operation: a pending request and a pending clear are dropped, and all outputs return to their reset values asynchronously.

## Configuration
- TILE_COLOR_BORDER_EN:
  - Defined: in-grid pixels whose tile-local x or y equals 0 output all-ones (white) on every channel, regardless of painted state. Latency is unchanged.
  - Undefined: no border logic; tile edges render like interior pixels.

## Test plan
- Reset release, r_in=8'h12, x=0,y=0 → after 2 clk, r_out=8'h12; upd_busy=0; LFSR first value equals SEED-derived reference model.
- upd_req with sel=5 (tx=1,ty=1), then frame_start → upd_ack pulses once in COMMIT; pixel x=144+128+3, y=35+64+3 outputs the LFSR colour captured at the commit cycle; pixel x=144,y=35 still passes r_in.
- upd_req and frame_start in the same cycle → no commit on that frame; commit and upd_ack on the next frame_start; a second upd_req while busy is ignored, with sel of the first request used.
- Tiles 0 and 15 painted, then clr_req plus upd_req sel=3 resolved on one frame_start → only tile 3 painted afterward.
- x=143 and x=144+512 with all tiles painted → pass-through; x=144 → tile 0 colour (border white when TILE_COLOR_BORDER_EN is defined).
- reset deasserted-to-asserted while PENDING → upd_busy=0 immediately; the next frame_start produces no commit and no upd_ack.
